reg_file_sb: RTL and testbench

- Architectural register file plus busy-bit scoreboard. It is the consumer end of the reg_id_t encoding defined in RegMap.
- Decode/issue presents reg_id_t source and destination IDs; writeback returns results by reg_id_t.
- Resolves fake registers (rnil, rip, rimm, rv0, rv8) to constants or side inputs.
- Real registers are indexed by the low 7 bits of the ID.
- Provides the issue-stall handshake for in-order issue.

---
 rtl/reg_file_sb.sv | 142 ++++++++++++++
 tb/tb_reg_file_sb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: architectural register file with busy-bit scoreboard.
// Consumes reg_id_t IDs: bit7=1 selects a real register (index id[6:0]),
// bit7=0 with value 0..4 selects a fake register (rnil, rip, rimm, rv0, rv8).
// Optional feature macro: REGFILE_BYPASS_EN (writeback-to-read/issue bypass).
module reg_file_sb #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREGS = 20,
  parameter logic [DATA_W-1:0] RFLAGS_RST = DATA_W'(2)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rd_id_a,
  input  logic [7:0]        rd_id_b,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              iss_valid,
  input  logic [7:0]        iss_dst,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [7:0]        wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic              err
);

  localparam int unsigned RFLAGS_IDX = 16;
  localparam logic [7:0] ID_RNIL = 8'h00;
  localparam logic [7:0] ID_RIP  = 8'h01;
  localparam logic [7:0] ID_RIMM = 8'h02;
  localparam logic [7:0] ID_RV8  = 8'h04;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_eff;
  logic [NREGS-1:0]  mask_a, mask_b, mask_d, mask_w;
  logic              fire;
  logic              err_set;

  function automatic logic is_real(input logic [7:0] id);
    return id[7] && (32'(id[6:0]) < NREGS);
  endfunction

  function automatic logic is_fake(input logic [7:0] id);
    return !id[7] && (id <= 8'h04);
  endfunction

  // One-hot select of a real register; all-zero for fake/illegal IDs.
  function automatic logic [NREGS-1:0] id_mask(input logic [7:0] id);
    return is_real(id) ? (NREGS'(1) << id[6:0]) : '0;
  endfunction

  // Decode all IDs into register select masks.
  always_comb begin
    mask_a = id_mask(rd_id_a);
    mask_b = id_mask(rd_id_b);
    mask_d = id_mask(iss_dst);
    mask_w = wb_valid ? id_mask(wb_dst) : '0;
  end

  // Stall when any real source or destination is still in flight.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    busy_eff = busy & ~mask_w;
`else
    busy_eff = busy;
`endif
    iss_ready = ~|(busy_eff & (mask_a | mask_b | mask_d));
    fire      = iss_valid & iss_ready;
  end

  // Illegal reads only matter when they are part of an issue request.
  always_comb begin
    err_set = 1'b0;
    if (iss_valid) begin
      if (!is_real(rd_id_a) && !is_fake(rd_id_a)) err_set = 1'b1;
      if (!is_real(rd_id_b) && !is_fake(rd_id_b)) err_set = 1'b1;
      if (!is_real(iss_dst) && (iss_dst != ID_RNIL)) err_set = 1'b1;
    end
    if (wb_valid && !is_real(wb_dst) && (wb_dst != ID_RNIL)) err_set = 1'b1;
  end

  // Source A read resolution.
  always_comb begin
    rd_data_a = '0;
    if (rd_id_a == ID_RIP) rd_data_a = pc;
    else if (rd_id_a == ID_RIMM) rd_data_a = imm;
    else if (rd_id_a == ID_RV8) rd_data_a = DATA_W'(8);
    for (int i = 0; i < int'(NREGS); i++) begin
      if (mask_a[i]) rd_data_a = regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (|(mask_a & mask_w)) rd_data_a = wb_data;
`endif
  end

  // Source B read resolution.
  always_comb begin
    rd_data_b = '0;
    if (rd_id_b == ID_RIP) rd_data_b = pc;
    else if (rd_id_b == ID_RIMM) rd_data_b = imm;
    else if (rd_id_b == ID_RV8) rd_data_b = DATA_W'(8);
    for (int i = 0; i < int'(NREGS); i++) begin
      if (mask_b[i]) rd_data_b = regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (|(mask_b & mask_w)) rd_data_b = wb_data;
`endif
  end

  // Register storage: writeback to real registers only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= (i == int'(RFLAGS_IDX)) ? RFLAGS_RST : '0;
      end
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (mask_w[i]) regs[i] <= wb_data;
      end
    end
  end

  // Scoreboard: writeback clears, issue sets; set wins on a same-cycle collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~mask_w) | (fire ? mask_d : '0);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb.
module tb_reg_file_sb;

  localparam logic [7:0] RNIL = 8'h00, RIP = 8'h01, RIMM = 8'h02, RV0 = 8'h03, RV8 = 8'h04;
  localparam logic [7:0] RAX = 8'h80, RCX = 8'h81, RDX = 8'h82, RBX = 8'h83, RFLAGS = 8'h90;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rd_id_a, rd_id_b, iss_dst, wb_dst;
  logic [63:0] pc, imm, wb_data, rd_data_a, rd_data_b;
  logic        iss_valid, iss_ready, wb_valid, err;

  int vectors = 0;
  int miscompares = 0;

  reg_file_sb dut (
    .clk(clk), .reset_n(reset_n),
    .rd_id_a(rd_id_a), .rd_id_b(rd_id_b),
    .pc(pc), .imm(imm),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change well away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    rd_id_a = RNIL; rd_id_b = RNIL; iss_dst = RNIL; wb_dst = RNIL;
    pc = '0; imm = '0; wb_data = '0;
    iss_valid = 1'b0; wb_valid = 1'b0;
    #12;
    chk("reset_ready", 64'(iss_ready), 64'd1);
    chk("reset_err", 64'(err), 64'd0);
    reset_n = 1'b1;
    step();

    // Post-reset reads
    rd_id_a = RFLAGS; rd_id_b = RAX; settle();
    chk("rflags_rst", rd_data_a, 64'h2);
    chk("rax_rst", rd_data_b, 64'h0);
    chk("ready_idle", 64'(iss_ready), 64'd1);
    chk("err_idle", 64'(err), 64'd0);

    // Fake registers
    pc = 64'h1000; imm = 64'hdead;
    rd_id_a = RIP; rd_id_b = RIMM; settle();
    chk("rip", rd_data_a, 64'h1000);
    chk("rimm", rd_data_b, 64'hdead);
    rd_id_a = RV8; rd_id_b = RNIL; settle();
    chk("rv8", rd_data_a, 64'd8);
    chk("rnil", rd_data_b, 64'd0);
    rd_id_a = RV0; settle();
    chk("rv0", rd_data_a, 64'd0);

    // Issue rcx <- rax + rdx
    iss_valid = 1'b1; rd_id_a = RAX; rd_id_b = RDX; iss_dst = RCX; settle();
    chk("issue_rcx_ready", 64'(iss_ready), 64'd1);
    step();
    // Dependent issue on rcx stalls
    rd_id_a = RCX; rd_id_b = RAX; iss_dst = RBX; settle();
    chk("dep_stall", 64'(iss_ready), 64'd0);
    step();
    chk("dep_stall_hold", 64'(iss_ready), 64'd0);
    // Writeback rcx=0x55
    iss_valid = 1'b0;
    wb_valid = 1'b1; wb_dst = RCX; wb_data = 64'h55; settle();
`ifdef REGFILE_BYPASS_EN
    chk("wb_cycle_ready", 64'(iss_ready), 64'd1);
    chk("wb_cycle_read", rd_data_a, 64'h55);
`else
    chk("wb_cycle_ready", 64'(iss_ready), 64'd0);
    chk("wb_cycle_read", rd_data_a, 64'h0);
`endif
    step();
    wb_valid = 1'b0; settle();
    chk("post_wb_ready", 64'(iss_ready), 64'd1);
    chk("post_wb_read", rd_data_a, 64'h55);

    // Same-cycle issue to rbx and writeback to rbx
    iss_valid = 1'b1; rd_id_a = RAX; rd_id_b = RDX; iss_dst = RBX;
    wb_valid = 1'b1; wb_dst = RBX; wb_data = 64'h7; settle();
    chk("collide_ready", 64'(iss_ready), 64'd1);
    step();
    iss_valid = 1'b0; wb_valid = 1'b0;
    rd_id_a = RBX; rd_id_b = RAX; iss_dst = RNIL; settle();
    chk("collide_data", rd_data_a, 64'h7);
    chk("collide_busy", 64'(iss_ready), 64'd0);
    // Clear rbx again by a writeback
    wb_valid = 1'b1; wb_dst = RBX; wb_data = 64'h9;
    step();
    wb_valid = 1'b0; settle();
    chk("rbx_cleared_ready", 64'(iss_ready), 64'd1);
    chk("rbx_cleared_data", rd_data_a, 64'h9);

    // Writeback to rnil is silently dropped
    wb_valid = 1'b1; wb_dst = RNIL; wb_data = 64'hff;
    step();
    wb_valid = 1'b0; rd_id_a = RAX; settle();
    chk("rnil_wb_err", 64'(err), 64'd0);
    chk("rnil_wb_rax", rd_data_a, 64'h0);
    // Writeback to rv0 sets sticky err
    wb_valid = 1'b1; wb_dst = RV0;
    step();
    wb_valid = 1'b0; settle();
    chk("rv0_wb_err", 64'(err), 64'd1);
    step(); step();
    chk("err_sticky", 64'(err), 64'd1);

    // Mid-stall async reset
    iss_valid = 1'b1; rd_id_a = RAX; rd_id_b = RDX; iss_dst = RCX;
    step();
    iss_valid = 1'b0; rd_id_a = RCX; rd_id_b = RFLAGS; settle();
    chk("pre_rst_stall", 64'(iss_ready), 64'd0);
    chk("pre_rst_rcx", rd_data_a, 64'h55);
    reset_n = 1'b0; settle();
    chk("rst_ready", 64'(iss_ready), 64'd1);
    chk("rst_rcx", rd_data_a, 64'h0);
    chk("rst_rflags", rd_data_b, 64'h2);
    chk("rst_err", 64'(err), 64'd0);
    step();
    reset_n = 1'b1;
    step();

    // Illegal read without issue request does not flag
    rd_id_a = 8'h95; rd_id_b = RNIL; iss_dst = RNIL; settle();
    chk("illegal_rd_data", rd_data_a, 64'h0);
    step();
    chk("illegal_rd_noiss_err", 64'(err), 64'd0);
    // Writeback to illegal 0x95 flags
    rd_id_a = RAX;
    wb_valid = 1'b1; wb_dst = 8'h95; wb_data = 64'h1;
    step();
    wb_valid = 1'b0; settle();
    chk("illegal_wb_err", 64'(err), 64'd1);
    // Reset, then an illegal issue destination flags but ready follows sources
    reset_n = 1'b0; settle();
    chk("rst2_err", 64'(err), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    iss_valid = 1'b1; rd_id_a = RAX; rd_id_b = RDX; iss_dst = RIP; settle();
    chk("bad_dst_ready", 64'(iss_ready), 64'd1);
    step();
    iss_valid = 1'b0; settle();
    chk("bad_dst_err", 64'(err), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
